mult_pipe: RTL and testbench

Parametrised, elastic pipelined integer multiplier for the execute stage. It computes all four RISC-V multiply flavours (MUL, MULH, MULHSU, MULHU) on XLEN-bit operands over STAGES pipeline stages, with sign handling carried per-operation. A valid/ready handshake on both sides sustains one operation per cycle and stalls cleanly under backpressure. A tag field carries the destination/ROB identifier alongside each operation.

---
 rtl/mult_pkg.sv | 41 ++++
 rtl/mult_pipe_stage.sv | 90 +++++++++
 rtl/mult_pipe.sv | 147 ++++++++++++++
 tb/tb_mult_pipe.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: types shared by the execute-stage decoder, the ALU and the
// pipelined multiplier.
//   mul_type_t   : RISC-V multiply flavour (MUL, MULH, MULHSU, MULHU)
//   MULT_TYPE_W  : encoded width of mul_type_t
//   opa_is_signed / opb_is_signed : operand signedness per flavour
package mult_pkg;

  localparam int MULT_TYPE_W = 2;

  typedef enum logic [MULT_TYPE_W-1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_type_t;

  function automatic logic opa_is_signed(input mul_type_t t);
    logic s;
    s = 1'b0;
    case (t)
      MUL:    s = 1'b0;
      MULH:   s = 1'b1;
      MULHSU: s = 1'b1;
      MULHU:  s = 1'b0;
    endcase
    return s;
  endfunction

  function automatic logic opb_is_signed(input mul_type_t t);
    logic s;
    s = 1'b0;
    case (t)
      MUL:    s = 1'b0;
      MULH:   s = 1'b1;
      MULHSU: s = 1'b0;
      MULHU:  s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// mult_pipe_stage: one stage of the elastic multiplier pipeline.
// Holds valid, type, tag, operands, operand sign bits and the running
// 2*XLEN partial sum. On load it accumulates opa times this stage's
// CHUNK-bit slice of opb, shifted into place. The last instance
// (IS_LAST=1) also applies the signed-operand correction to the high half.
// Ports:
//   clock, reset (sync, active-low), clr (squash), load (stage may load)
//   prev_*  : contents of the upstream stage (or the accepted input)
//   vld, mtype, tag, opa, opb, sum, opa_neg, opb_neg : this stage's registers
module mult_pipe_stage
  import mult_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int STAGES  = 4,
  parameter int TAG_W   = 6,
  parameter int IDX     = 0,
  parameter bit IS_LAST = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              load,
  input  logic              prev_vld,
  input  mul_type_t         prev_type,
  input  logic [TAG_W-1:0]  prev_tag,
  input  logic [XLEN-1:0]   prev_opa,
  input  logic [XLEN-1:0]   prev_opb,
  input  logic [2*XLEN-1:0] prev_sum,
  input  logic              prev_opa_neg,
  input  logic              prev_opb_neg,
  output logic              vld,
  output mul_type_t         mtype,
  output logic [TAG_W-1:0]  tag,
  output logic [XLEN-1:0]   opa,
  output logic [XLEN-1:0]   opb,
  output logic [2*XLEN-1:0] sum,
  output logic              opa_neg,
  output logic              opb_neg
);

  localparam int CHUNK = XLEN / STAGES;
  localparam int W2    = 2 * XLEN;

  // The unsigned product treats a negative operand x as x + 2^XLEN, which
  // adds the other operand into the high half once; remove it again.
  function automatic logic [W2-1:0] sign_fix(
    input logic [W2-1:0]   s,
    input logic            a_neg,
    input logic            b_neg,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic [XLEN-1:0] hi;
    hi = s[W2-1:XLEN] - (a_neg ? b : '0) - (b_neg ? a : '0);
    return {hi, s[XLEN-1:0]};
  endfunction

  logic [CHUNK-1:0] chunk;
  logic [W2-1:0]    partial;
  logic [W2-1:0]    acc;
  logic [W2-1:0]    sum_next;

  always_comb begin
    chunk    = prev_opb[IDX*CHUNK +: CHUNK];
    partial  = ({{XLEN{1'b0}}, prev_opa} * {{(W2-CHUNK){1'b0}}, chunk}) << (IDX*CHUNK);
    acc      = prev_sum + partial;
    sum_next = IS_LAST ? sign_fix(acc, prev_opa_neg, prev_opb_neg, prev_opa, prev_opb) : acc;
  end

  always_ff @(posedge clock) begin
    if (!reset || clr) begin
      vld <= 1'b0;
    end else if (load) begin
      vld <= prev_vld;
    end
  end

  always_ff @(posedge clock) begin
    if (load && prev_vld) begin
      mtype   <= prev_type;
      tag     <= prev_tag;
      opa     <= prev_opa;
      opb     <= prev_opb;
      sum     <= sum_next;
      opa_neg <= prev_opa_neg;
      opb_neg <= prev_opb_neg;
    end
  end

endmodule

// File: rtl/mult_pipe.sv
// mult_pipe: elastic STAGES-deep pipelined XLEN x XLEN multiplier for
// MUL / MULH / MULHSU / MULHU with a passthrough tag.
// Ports:
//   clock, reset (sync, active-low)
//   in_valid/in_ready, in_opa, in_opb, in_type, in_tag : operation input
//   out_valid/out_ready, out_result, out_tag            : result output
//   flush : squash all in-flight work (only with MULT_PIPE_FLUSH_EN)
// Optional feature macro: MULT_PIPE_FLUSH_EN adds the flush port.
// in_ready depends combinationally on out_ready through the advance chain;
// no in_* input reaches any out_* output without a register.
module mult_pipe
  import mult_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int STAGES = 4,
  parameter int TAG_W  = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_opa,
  input  logic [XLEN-1:0]  in_opb,
  input  mul_type_t        in_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
`ifdef MULT_PIPE_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  localparam int LAST = STAGES - 1;

  logic clr;
`ifdef MULT_PIPE_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  logic              vld_p     [STAGES];
  mul_type_t         type_p    [STAGES];
  logic [TAG_W-1:0]  tag_p     [STAGES];
  logic [XLEN-1:0]   opa_p     [STAGES];
  logic [XLEN-1:0]   opb_p     [STAGES];
  logic [2*XLEN-1:0] sum_p     [STAGES];
  logic              opa_neg_p [STAGES];
  logic              opb_neg_p [STAGES];
  logic              load_p    [STAGES];
  logic              accept;

  // A stage may load when empty or when its content moves on this edge;
  // the ripple from the output side makes bubbles collapse under stall.
  always_comb begin
    load_p[LAST] = !vld_p[LAST] || out_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      load_p[k] = !vld_p[k] || load_p[k+1];
    end
  end

  assign in_ready = load_p[0] && reset && !clr;
  assign accept   = in_valid && in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic              p_vld;
    mul_type_t         p_type;
    logic [TAG_W-1:0]  p_tag;
    logic [XLEN-1:0]   p_opa;
    logic [XLEN-1:0]   p_opb;
    logic [2*XLEN-1:0] p_sum;
    logic              p_opa_neg;
    logic              p_opb_neg;

    if (k == 0) begin : g_head
      // Stage 0 boundary: accepted operation enters, sign bits decoded once
      assign p_vld     = accept;
      assign p_type    = in_type;
      assign p_tag     = in_tag;
      assign p_opa     = in_opa;
      assign p_opb     = in_opb;
      assign p_sum     = '0;
      assign p_opa_neg = in_opa[XLEN-1] && opa_is_signed(in_type);
      assign p_opb_neg = in_opb[XLEN-1] && opb_is_signed(in_type);
    end else begin : g_body
      // Stage k-1 -> stage k boundary
      assign p_vld     = vld_p[k-1];
      assign p_type    = type_p[k-1];
      assign p_tag     = tag_p[k-1];
      assign p_opa     = opa_p[k-1];
      assign p_opb     = opb_p[k-1];
      assign p_sum     = sum_p[k-1];
      assign p_opa_neg = opa_neg_p[k-1];
      assign p_opb_neg = opb_neg_p[k-1];
    end

    mult_pipe_stage #(
      .XLEN    (XLEN),
      .STAGES  (STAGES),
      .TAG_W   (TAG_W),
      .IDX     (k),
      .IS_LAST (k == LAST)
    ) u_stage (
      .clock        (clock),
      .reset        (reset),
      .clr          (clr),
      .load         (load_p[k]),
      .prev_vld     (p_vld),
      .prev_type    (p_type),
      .prev_tag     (p_tag),
      .prev_opa     (p_opa),
      .prev_opb     (p_opb),
      .prev_sum     (p_sum),
      .prev_opa_neg (p_opa_neg),
      .prev_opb_neg (p_opb_neg),
      .vld          (vld_p[k]),
      .mtype        (type_p[k]),
      .tag          (tag_p[k]),
      .opa          (opa_p[k]),
      .opb          (opb_p[k]),
      .sum          (sum_p[k]),
      .opa_neg      (opa_neg_p[k]),
      .opb_neg      (opb_neg_p[k])
    );
  end

  // Output boundary: half select from the last stage, zero while empty
  logic [XLEN-1:0] sel_result;

  always_comb begin
    sel_result = sum_p[LAST][2*XLEN-1:XLEN];
    case (type_p[LAST])
      MUL:    sel_result = sum_p[LAST][XLEN-1:0];
      MULH:   sel_result = sum_p[LAST][2*XLEN-1:XLEN];
      MULHSU: sel_result = sum_p[LAST][2*XLEN-1:XLEN];
      MULHU:  sel_result = sum_p[LAST][2*XLEN-1:XLEN];
    endcase
  end

  assign out_valid  = vld_p[LAST] && !clr;
  assign out_result = vld_p[LAST] ? sel_result  : '0;
  assign out_tag    = vld_p[LAST] ? tag_p[LAST] : '0;

endmodule

// File: tb/tb_mult_pipe.sv
module tb_mult_pipe;
  import mult_pkg::*;

  localparam int XLEN   = 64;
  localparam int STAGES = 4;
  localparam int TAG_W  = 6;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_opa;
  logic [XLEN-1:0]  in_opb;
  mul_type_t        in_type;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             flush;

  always #5 clock = ~clock;

  mult_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opa     (in_opa),
    .in_opb     (in_opb),
    .in_type    (in_type),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
`ifdef MULT_PIPE_FLUSH_EN
    ,
    .flush      (flush)
`endif
  );

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  res;
    int               acc_cyc;
    bit               chk_lat;
  } sb_t;

  sb_t              sb_q[$];
  sb_t              sb_e;
  int               n_vec = 0;
  int               n_err = 0;
  int               cyc   = 0;
  logic [XLEN-1:0]  exp_cur;
  bit               chk_cur;
  bit               acc_flag;
  bit               stall_prev;
  logic [XLEN-1:0]  held_res;
  logic [TAG_W-1:0] held_tag;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_mul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                              input mul_type_t t);
    logic signed [2*XLEN+1:0] ae;
    logic signed [2*XLEN+1:0] be;
    logic signed [2*XLEN+1:0] p;
    ae = (t == MULH || t == MULHSU) ? {{(XLEN+2){a[XLEN-1]}}, a} : {{(XLEN+2){1'b0}}, a};
    be = (t == MULH) ? {{(XLEN+2){b[XLEN-1]}}, b} : {{(XLEN+2){1'b0}}, b};
    p  = ae * be;
    return (t == MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  // Sample 1 ns before each rising edge: handshakes seen here complete at that edge.
  always @(negedge clock) begin
    #4;
    cyc++;
    chk("in_ready", 64'(reset && !flush && (sb_q.size() < STAGES || out_ready)), 64'(in_ready));
    if (!reset || flush) begin
      if (flush) chk("out_valid_flush", 64'(out_valid), 64'd0);
      sb_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (sb_q.size() == 0) chk("out_valid_idle", 64'(out_valid), 64'd0);
      if (stall_prev) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_result", out_result, held_res);
        chk("hold_tag", 64'(out_tag), 64'(held_tag));
      end
      if (out_valid && out_ready && sb_q.size() != 0) begin
        sb_e = sb_q.pop_front();
        chk("result", out_result, sb_e.res);
        chk("tag", 64'(out_tag), 64'(sb_e.tag));
        if (sb_e.chk_lat) chk("latency", 64'(cyc - sb_e.acc_cyc), 64'(STAGES));
      end
      stall_prev = out_valid && !out_ready;
      held_res   = out_result;
      held_tag   = out_tag;
      if (in_valid && in_ready) begin
        sb_q.push_back('{in_tag, exp_cur, cyc, chk_cur});
        acc_flag = 1'b1;
      end
    end
  end

  task automatic send(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input mul_type_t t,
                      input logic [TAG_W-1:0] tg, input logic [XLEN-1:0] e, input bit cl);
    int n;
    @(negedge clock);
    in_valid = 1'b1;
    in_opa   = a;
    in_opb   = b;
    in_type  = t;
    in_tag   = tg;
    exp_cur  = e;
    chk_cur  = cl;
    acc_flag = 1'b0;
    n = 0;
    do begin
      @(posedge clock);
      n++;
    end while (!acc_flag && n < 50);
    if (!acc_flag) chk("accept_timeout", 64'(acc_flag), 64'd1);
  endtask

  task automatic send_rand(input logic [TAG_W-1:0] tg);
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    mul_type_t       t;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    t = mul_type_t'($urandom_range(0, 3));
    send(a, b, t, tg, ref_mul(a, b, t), 1'b0);
  endtask

  task automatic idle();
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clock);
      n++;
    end
    chk("drain", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    flush      = 1'b0;
    in_opa     = '0;
    in_opb     = '0;
    in_type    = MUL;
    in_tag     = '0;
    exp_cur    = '0;
    chk_cur    = 1'b0;
    acc_flag   = 1'b0;
    stall_prev = 1'b0;
    held_res   = '0;
    held_tag   = '0;

    repeat (2) @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #4;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);

    // MUL 3 x 5
    send(64'd3, 64'd5, MUL, 6'd7, 64'd15, 1'b1);
    idle();
    drain();

    // all-ones operands, back to back
    send('1, '1, MULH,   6'd1, 64'h0, 1'b1);
    send('1, '1, MULHU,  6'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    send('1, '1, MULHSU, 6'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    send('1, '1, MUL,    6'd4, 64'h1, 1'b1);
    idle();
    drain();

    // most-negative operands
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, MULH,   6'd5, 64'h4000_0000_0000_0000, 1'b1);
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, MULHSU, 6'd6, 64'hC000_0000_0000_0000, 1'b1);
    idle();
    drain();

    // random stream with a consumer stall
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand(6'(i));
        idle();
      end
      begin
        repeat (3) @(negedge clock);
        out_ready = 1'b0;
        repeat (6) @(negedge clock);
        out_ready = 1'b1;
      end
    join
    drain();

    // reset with operations in flight
    send_rand(6'd20);
    send_rand(6'd21);
    send_rand(6'd22);
    @(negedge clock);
    in_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #4;
    chk("rst2_out_valid", 64'(out_valid), 64'd0);
    chk("rst2_out_result", out_result, 64'd0);
    chk("rst2_out_tag", 64'(out_tag), 64'd0);
    repeat (6) @(negedge clock);
    send(64'd2, 64'd2, MUL, 6'd9, 64'd4, 1'b1);
    idle();
    drain();

`ifdef MULT_PIPE_FLUSH_EN
    // flush a full pipeline while an operation is offered
    @(negedge clock);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_rand(6'(30 + i));
    @(negedge clock);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_opa   = 64'd7;
    in_opb   = 64'd6;
    in_type  = MUL;
    in_tag   = 6'd12;
    exp_cur  = 64'd42;
    chk_cur  = 1'b1;
    acc_flag = 1'b0;
    @(posedge clock);
    #1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("flush_no_accept", 64'(acc_flag), 64'd0);
    repeat (5) @(negedge clock);
    send(64'd7, 64'd6, MUL, 6'd12, 64'd42, 1'b1);
    idle();
    drain();
`endif

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
